// File: rtl/card_pair_shuffler.sv
// Card-pair layout generator: fills a deck with symbol pairs, then Fisher-Yates shuffles it from a 16-bit LFSR.
// Optional CARD_PAIR_SHUFFLER_RESEED_EN adds seed_ld/seed_in for reproducible boards.
module card_pair_shuffler #(
    parameter int          NUM_PAIRS = 8,
    parameter int          SYM_W     = 3,
    parameter logic [15:0] SEED      = 16'hACE1
) (
    input  logic                             clk,
    input  logic                             resetn,
    input  logic                             start,
`ifdef CARD_PAIR_SHUFFLER_RESEED_EN
    input  logic                             seed_ld,
    input  logic [15:0]                      seed_in,
`endif
    output logic                             busy,
    output logic                             done,
    output logic [2*NUM_PAIRS*SYM_W-1:0]     map
);

    localparam int          N       = 2 * NUM_PAIRS;
    localparam int          IDX_W   = $clog2(N);
    localparam logic [15:0] SEED_NZ = (SEED == 16'h0000) ? 16'h0001 : SEED;

    if (NUM_PAIRS < 2 || NUM_PAIRS > 32) begin : g_bad_num_pairs
        $error("card_pair_shuffler: NUM_PAIRS must be in 2..32");
    end
    if ((1 << SYM_W) < NUM_PAIRS) begin : g_bad_sym_w
        $error("card_pair_shuffler: SYM_W too narrow for NUM_PAIRS symbols");
    end

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_INIT,
        ST_SHUFFLE,
        ST_DONE
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [15:0]        lfsr;
    logic [SYM_W-1:0]   deck [N];
    logic [IDX_W-1:0]   idx;
    logic [IDX_W-1:0]   mask;
    logic [IDX_W-1:0]   r;
    logic               accept;

    // The LFSR advances every cycle out of reset, independent of the FSM.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            lfsr <= SEED_NZ;
`ifdef CARD_PAIR_SHUFFLER_RESEED_EN
        end else if (seed_ld) begin
            lfsr <= (seed_in == 16'h0000) ? 16'h0001 : seed_in;
`endif
        end else begin
            lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
        end
    end

    // Smearing idx right gives the smallest all-ones mask covering 0..idx.
    always_comb begin
        mask = idx;
        for (int k = 1; k < IDX_W; k++) begin
            mask = mask | (idx >> k);
        end
    end

    assign r      = lfsr[IDX_W-1:0] & mask;
    assign accept = (r <= idx);

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:    if (start) state_nxt = ST_INIT;
            ST_INIT:    state_nxt = ST_SHUFFLE;
            ST_SHUFFLE: if (accept && idx == IDX_W'(1)) state_nxt = ST_DONE;
            ST_DONE:    state_nxt = start ? ST_INIT : ST_IDLE;
            default:    state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state <= ST_IDLE;
            idx   <= '0;
        end else begin
            state <= state_nxt;
            if (state == ST_INIT) begin
                idx <= IDX_W'(N - 1);
            end else if (state == ST_SHUFFLE && accept) begin
                idx <= idx - IDX_W'(1);
            end
        end
    end

    // NOTE: deck is working storage rewritten in INIT before any use, so it carries no reset.
    always_ff @(posedge clk) begin
        if (state == ST_INIT) begin
            for (int s = 0; s < N; s++) begin
                deck[s] <= SYM_W'(s >> 1);
            end
        end else if (state == ST_SHUFFLE && accept) begin
            // NOTE: nonblocking writes let both sides of the swap read pre-swap values.
            deck[idx] <= deck[r];
            deck[r]   <= deck[idx];
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            map  <= '0;
            done <= 1'b0;
        end else begin
            done <= (state == ST_DONE);
            if (state == ST_DONE) begin
                for (int s = 0; s < N; s++) begin
                    map[s*SYM_W +: SYM_W] <= deck[s];
                end
            end
        end
    end

    assign busy = (state == ST_INIT) || (state == ST_SHUFFLE);

endmodule

// File: tb/tb_card_pair_shuffler.sv
// Randomised self-checking bench for card_pair_shuffler: 8-pair and 18-pair instances against a Fisher-Yates reference model.
module tb_card_pair_shuffler;

    logic         clk;
    logic         resetn;
    logic         start8;
    logic         start18;
    logic         seed_ld;
    logic [15:0]  seed_in;
    logic         busy8;
    logic         done8;
    logic [47:0]  map8;
    logic         busy18;
    logic         done18;
    logic [179:0] map18;
    logic [15:0]  lm;

    int checks = 0;
    int errors = 0;

    card_pair_shuffler #(.NUM_PAIRS(8), .SYM_W(3), .SEED(16'hACE1)) dut8 (
        .clk    (clk),
        .resetn (resetn),
        .start  (start8),
`ifdef CARD_PAIR_SHUFFLER_RESEED_EN
        .seed_ld(seed_ld),
        .seed_in(seed_in),
`endif
        .busy   (busy8),
        .done   (done8),
        .map    (map8)
    );

    card_pair_shuffler #(.NUM_PAIRS(18), .SYM_W(5), .SEED(16'hACE1)) dut18 (
        .clk    (clk),
        .resetn (resetn),
        .start  (start18),
`ifdef CARD_PAIR_SHUFFLER_RESEED_EN
        .seed_ld(seed_ld),
        .seed_in(seed_in),
`endif
        .busy   (busy18),
        .done   (done18),
        .map    (map18)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
    endfunction

    // Reference LFSR: value held during the cycle following each clock edge.
    always @(posedge clk) begin
        if (!resetn)      lm <= 16'hACE1;
`ifdef CARD_PAIR_SHUFFLER_RESEED_EN
        else if (seed_ld) lm <= (seed_in == 16'h0) ? 16'h0001 : seed_in;
`endif
        else              lm <= lfsr_step(lm);
    end

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Fisher-Yates with rejection sampling; la is the LFSR value during the INIT cycle.
    function automatic void model_shuffle(input int np, input int sw, input logic [15:0] la,
                                          output logic [255:0] m, output int draws);
        int n = 2 * np;
        int iw = $clog2(n);
        int deck [64];
        int i;
        int r;
        int t;
        int msk;
        logic [15:0] s;
        for (int k = 0; k < n; k++) deck[k] = k / 2;
        s = la;
        i = n - 1;
        draws = 0;
        while (i >= 1 && draws < 100000) begin
            s = lfsr_step(s);
            draws++;
            msk = (1 << $clog2(i + 1)) - 1;
            r = int'(s) & ((1 << iw) - 1) & msk;
            if (r <= i) begin
                t = deck[i];
                deck[i] = deck[r];
                deck[r] = t;
                i--;
            end
        end
        m = '0;
        for (int k = 0; k < n; k++)
            for (int b = 0; b < sw; b++)
                m[k*sw + b] = deck[k][b];
    endfunction

    function automatic logic pairs_ok(input int np, input int sw, input logic [255:0] m);
        int cnt [64];
        int sym;
        for (int k = 0; k < 64; k++) cnt[k] = 0;
        for (int k = 0; k < 2 * np; k++) begin
            sym = 0;
            for (int b = 0; b < sw; b++) sym = sym | (int'(m[k*sw + b]) << b);
            cnt[sym]++;
        end
        for (int k = 0; k < 64; k++) begin
            if (k < np && cnt[k] != 2) return 1'b0;
            if (k >= np && cnt[k] != 0) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic wait_done(input bit sel, input int budget, output int c);
        c = 0;
        do begin
            tick();
            c++;
        end while (!(sel ? done18 : done8) && c < budget);
    endtask

    task automatic run_b2b(input bit sel, input int np, input int sw, input int nruns);
        logic [255:0] em;
        logic [255:0] cur;
        logic [255:0] prev;
        logic [15:0]  la;
        int d;
        int c;
        if (sel) start18 = 1'b1; else start8 = 1'b1;
        tick();
        la = lm;
        prev = '0;
        for (int run = 0; run < nruns; run++) begin
            model_shuffle(np, sw, la, em, d);
            wait_done(sel, d + 60, c);
            cur = sel ? 256'(map18) : 256'(map8);
            check("b2b_latency", c, d + 2);
            check("b2b_map", cur, em);
            check("b2b_pairs", pairs_ok(np, sw, cur), 1'b1);
            if (run > 0) check("b2b_differs", (cur != prev), 1'b1);
            prev = cur;
            la = lm;
        end
        start8 = 1'b0;
        start18 = 1'b0;
        wait_done(sel, 5000, c);
        repeat (3) tick();
    endtask

    task automatic seeded_run(input logic [15:0] sv, output logic [255:0] m);
        logic [255:0] em;
        int d;
        int c;
        seed_ld = 1'b1;
        seed_in = sv;
        tick();
        seed_ld = 1'b0;
        start8 = 1'b1;
        tick();
        start8 = 1'b0;
        model_shuffle(8, 3, lm, em, d);
        wait_done(1'b0, d + 60, c);
        check("seed_latency", c, d + 2);
        check("seed_map", map8, em);
        m = map8;
        tick();
    endtask

    initial begin
        logic [255:0] em;
        logic [255:0] old;
        logic [15:0]  la;
        int d;
        int c;
        int ndone;
        int done_at;
        bit early;
        bit idle_bad;
        logic [255:0] ma;
        logic [255:0] mb;

        resetn  = 1'b0;
        start8  = 1'b0;
        start18 = 1'b0;
        seed_ld = 1'b0;
        seed_in = 16'h0;
        repeat (3) tick();
        check("rst_map8", map8, 0);
        check("rst_busy8", busy8, 0);
        check("rst_done8", done8, 0);
        check("rst_map18", map18, 0);
        check("rst_busy18", busy18, 0);

        resetn = 1'b1;
        idle_bad = 1'b0;
        for (int k = 0; k < 100; k++) begin
            tick();
            if (map8 != 0 || busy8 || done8 || map18 != 0 || busy18 || done18) idle_bad = 1'b1;
        end
        check("idle_stable", idle_bad, 0);

        // Single run with a stray start raised mid-shuffle.
        start8 = 1'b1;
        tick();
        start8 = 1'b0;
        check("busy_after_accept", busy8, 1);
        la = lm;
        model_shuffle(8, 3, la, em, d);
        old = map8;
        ndone = 0;
        done_at = 0;
        early = 1'b0;
        for (int k = 1; k <= d + 42; k++) begin
            tick();
            if (done8) begin
                ndone++;
                done_at = k;
            end
            if (ndone == 0 && 256'(map8) != old) early = 1'b1;
            start8 = (k == 5);
        end
        start8 = 1'b0;
        check("single_done_count", ndone, 1);
        check("single_latency", done_at, d + 2);
        check("single_map", map8, em);
        check("single_pairs", pairs_ok(8, 3, map8), 1);
        check("single_map_early", early, 0);
        check("single_busy_end", busy8, 0);

        // Reset while busy aborts and clears the map.
        start8 = 1'b1;
        tick();
        start8 = 1'b0;
        repeat (6) tick();
        check("busy_midrun", busy8, 1);
        resetn = 1'b0;
        tick();
        check("abort_map", map8, 0);
        check("abort_busy", busy8, 0);
        check("abort_done", done8, 0);
        resetn = 1'b1;
        tick();
        check("abort_no_done", done8, 0);
        start8 = 1'b1;
        tick();
        start8 = 1'b0;
        model_shuffle(8, 3, lm, em, d);
        wait_done(1'b0, d + 60, c);
        check("post_reset_latency", c, d + 2);
        check("post_reset_map", map8, em);
        tick();

`ifdef CARD_PAIR_SHUFFLER_RESEED_EN
        seeded_run(16'h1234, ma);
        seeded_run(16'h1234, mb);
        check("reseed_repeat", mb, ma);
        seeded_run(16'h0000, ma);
        seeded_run(16'h0001, mb);
        check("reseed_zero", ma, mb);
`endif

        run_b2b(1'b0, 8, 3, 50);
        run_b2b(1'b1, 18, 5, 50);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/card_pair_shuffler.md
Name: card_pair_shuffler

Overview:
- Generates a randomised card-pair layout for the Card-Flip board. Parametrised in pair count and symbol width.
- Fills a deck so that pair p carries symbol p on two slots, then runs an unbiased Fisher-Yates shuffle driven by an internal 16-bit LFSR.
- Sits between the game controller (start/done handshake) and the board renderer/compare logic, which read the flattened map.

Parameters:
- NUM_PAIRS, 8, number of symbol pairs; board has 2*NUM_PAIRS slots; legal range 2..32.
- SYM_W, 3, bits per slot symbol; 2**SYM_W >= NUM_PAIRS is required (elaboration error otherwise).
- SEED, 16'hACE1, LFSR reset value; value 0 is replaced by 16'h0001.
- Localparams: N = 2*NUM_PAIRS; IDX_W = clog2(N).

Ports:
- clk  in  1  clock
- resetn  in  1  reset
- start  in  1  request a new shuffle; level-sampled, accepted only in IDLE or DONE.
- busy  out  1  high from INIT through SHUFFLE.
- done  out  1  one-cycle pulse when map is updated.
- map  out  N*SYM_W  slot s symbol at map[s*SYM_W +: SYM_W]; slot 0 in LSBs.
- Interface rule: reset resetn, synchronous, active-low; clock clk.

Behaviour:
- Reset values: map=0, done=0, busy=0, state=IDLE, LFSR=SEED. Reset mid-shuffle aborts the run and clears map.
- LFSR: Fibonacci, x^16+x^14+x^13+x^11+1, shifts left every cycle out of reset regardless of state; new bit = s[15]^s[13]^s[12]^s[10].
- FSM states:
  - IDLE: start -> INIT.
  - INIT (1 cycle): deck[s] = s>>1 for all s in parallel; i = N-1; busy=1. -> SHUFFLE.
  - SHUFFLE (one draw per cycle): mask = 2**clog2(i+1)-1; r = lfsr[IDX_W-1:0] & mask.
    - If r <= i: swap deck[i] and deck[r] (r==i is a legal no-op swap); then if i==1 -> DONE, else i = i-1.
    - If r > i: reject; no swap; i unchanged; retry next cycle.
  - DONE (1 cycle): map <= deck; done=1; busy=0. start -> INIT, else -> IDLE.
- map is updated only on the DONE cycle. It stays stable through the following run until that run's DONE.
- start while busy is ignored; no queuing.
- Latency from the start-accept edge to done: >= N+1 cycles (INIT, N-1 accepted draws, DONE). Each draw rejects with probability < 1/2.
- Invariant at every done: each symbol 0..NUM_PAIRS-1 appears exactly twice; symbols >= NUM_PAIRS never appear.
- Swap writes to deck[i] and deck[r] use the pre-swap values from the same cycle (nonblocking semantics).

Optional Feature:
- Macro CARD_PAIR_SHUFFLER_RESEED_EN.
- When defined, adds ports seed_ld (in, 1) and seed_in (in, 16).
  - seed_ld=1 loads the LFSR with seed_in (0 maps to 16'h0001) that cycle, overriding the shift.
  - Legal in any state; a load during SHUFFLE takes effect on the next draw.
  - This allows reproducible boards: same seed loaded, then start on the next cycle, gives an identical map.
- When undefined, the ports do not exist and the LFSR is free-running from SEED.

Test Plan:
- Reset for 3 cycles with defaults -> map=0, busy=0, done=0. Hold start=0 for 100 cycles -> outputs unchanged.
- Pulse start once (defaults) -> busy on the next edge; done pulses exactly once, >= 17 cycles after accept. Map has each of 0..7 exactly twice across 16 slots.
- Raise start again 5 cycles into the shuffle -> ignored: exactly one done; map changes only on the done cycle.
- Assert resetn=0 while busy -> next edge map=0, busy=0, no done. After release, start completes normally.
- Run 50 back-to-back shuffles (start held high) -> the pair invariant holds every done, and no two consecutive maps are identical. Repeat with NUM_PAIRS=18, SYM_W=5 (6x6 board, 36 slots).
- With CARD_PAIR_SHUFFLER_RESEED_EN: seed_ld with seed_in=16'h1234, start the next cycle, record map. Repeat the same sequence -> identical map. Seed_in=0 -> same result as 16'h0001.
